// File: rtl/pixel_line_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_line_feeder_if
// Description : Bus bundle between the pixel line feeder, its frame memory and
//               the kernel-side control/stream signals.
//               master : the feeder (drives memory strobe/address, pixel stream,
//                        status; receives start, lineRequest, read data)
//               slave  : the environment (memory + kernel + host control)
// Ports       : start, lineRequest, memRdData  -> feeder
//               memRdEn, memAddr, pixelOut, pixelOutValid, busy, done <- feeder
// Revision    : 1.0  initial release
// ============================================================================
interface pixel_line_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 18
) ();
  logic                  start;
  logic                  lineRequest;
  logic                  memRdEn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memRdData;
  logic [DATA_WIDTH-1:0] pixelOut;
  logic                  pixelOutValid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, lineRequest, memRdData,
    output memRdEn, memAddr, pixelOut, pixelOutValid, busy, done
  );

  modport slave (
    output start, lineRequest, memRdData,
    input  memRdEn, memAddr, pixelOut, pixelOutValid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pixel_line_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pixel_line_feeder
// Description : Frame source for the 3x3 edge-detection kernel. Reads a
//               grayscale frame from a synchronous-read memory and streams it
//               as gap-free valid bursts: PRIME_LINES lines after start, one
//               line per lineRequest rising edge, then PAD_LINES zero lines.
// Ports       : clk, rst (sync, active-high)
//               bus (master modport): start, lineRequest, memRdData in;
//                 memRdEn, memAddr, pixelOut, pixelOutValid, busy, done out
// Revision    : 1.0  initial release
// ============================================================================
module pixel_line_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic                clk,
  input  logic                rst,
  pixel_line_feeder_if.master bus
);

  localparam int c_COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int c_TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
  localparam int c_LINE_W      = $clog2(c_TOTAL_LINES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    WAIT_REQ = 3'd2,
    LINE     = 3'd3,
    PAD_WAIT = 3'd4,
    PAD      = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [c_COL_W-1:0]    r_colCnt;
  logic [c_LINE_W-1:0]   r_lineCnt;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic                  r_reqCur;
  logic                  r_reqPrev;
  logic                  r_pending;
  logic                  r_vld1;
  logic                  r_zero1;
  logic                  r_last1;
  logic                  r_last2;
  logic [DATA_WIDTH-1:0] r_pixelOut;
  logic                  r_pixelOutValid;
  logic                  r_done;

  logic w_edge;
  logic w_reqAvail;
  logic w_memRd;
  logic w_burst;
  logic w_colLast;
  logic w_allLines;
  logic w_lastBeat;
  logic w_consume;
  logic w_finish;

  assign w_edge     = r_reqCur & ~r_reqPrev;
  // A fresh edge is acted on in the same cycle it is detected, so a waiting
  // FSM starts its burst two cycles after lineRequest is first sampled high.
  assign w_reqAvail = r_pending | w_edge;
  assign w_memRd    = (r_state == PRIME) || (r_state == LINE);
  assign w_burst    = w_memRd || (r_state == PAD);
  assign w_colLast  = (r_colCnt == c_COL_W'(IMG_WIDTH - 1));
  assign w_allLines = (r_lineCnt == c_LINE_W'(c_TOTAL_LINES));
  assign w_lastBeat = w_burst && w_colLast &&
                      (r_lineCnt == c_LINE_W'(c_TOTAL_LINES - 1));

  // PAD_WAIT doubles as the drain state once every line has been issued: the
  // FSM holds there until the last pixel leaves the output register, so that
  // done, busy falling and the return to IDLE all land on the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_consume   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_nextState = PRIME;
      end
      PRIME: begin
        if (w_colLast && (r_lineCnt == c_LINE_W'(PRIME_LINES - 1)))
          w_nextState = (PRIME_LINES >= IMG_HEIGHT) ? PAD_WAIT : WAIT_REQ;
      end
      WAIT_REQ: begin
        if (w_reqAvail) begin
          w_nextState = LINE;
          w_consume   = 1'b1;
        end
      end
      LINE: begin
        if (w_colLast)
          w_nextState = (r_lineCnt == c_LINE_W'(IMG_HEIGHT - 1)) ? PAD_WAIT : WAIT_REQ;
      end
      PAD_WAIT: begin
        if (w_allLines) begin
          if (r_last2) begin
            w_nextState = IDLE;
            w_finish    = 1'b1;
          end
        end else if (w_reqAvail) begin
          w_nextState = PAD;
          w_consume   = 1'b1;
        end
      end
      PAD: begin
        if (w_colLast) w_nextState = PAD_WAIT;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_colCnt        <= '0;
      r_lineCnt       <= '0;
      r_memAddr       <= '0;
      r_reqCur        <= 1'b0;
      r_reqPrev       <= 1'b0;
      r_pending       <= 1'b0;
      r_vld1          <= 1'b0;
      r_zero1         <= 1'b0;
      r_last1         <= 1'b0;
      r_last2         <= 1'b0;
      r_pixelOut      <= '0;
      r_pixelOutValid <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_reqCur  <= bus.lineRequest;
      r_reqPrev <= r_reqCur;

      // Single-entry request queue: a second edge while one is queued is lost.
      if (r_state == IDLE || w_consume) r_pending <= 1'b0;
      else if (w_edge)                  r_pending <= 1'b1;

      // Line counter runs through memory lines and then pad lines.
      if (r_state == IDLE || w_finish) begin
        r_colCnt  <= '0;
        r_lineCnt <= '0;
      end else if (w_burst) begin
        if (w_colLast) begin
          r_colCnt  <= '0;
          r_lineCnt <= r_lineCnt + 1'b1;
        end else begin
          r_colCnt  <= r_colCnt + 1'b1;
        end
      end

      if (r_state == IDLE || w_finish) r_memAddr <= '0;
      else if (w_memRd)                r_memAddr <= r_memAddr + 1'b1;

      // Stage 1 lines up with memRdData; stage 2 is the output register.
      r_vld1          <= w_burst;
      r_zero1         <= (r_state == PAD);
      r_last1         <= w_lastBeat;
      r_last2         <= r_last1;
      r_pixelOutValid <= r_vld1;
      r_pixelOut      <= (r_vld1 && !r_zero1) ? bus.memRdData : '0;
      r_done          <= w_finish;
    end
  end

  assign bus.memRdEn       = w_memRd;
  assign bus.memAddr       = r_memAddr;
  assign bus.pixelOut      = r_pixelOut;
  assign bus.pixelOutValid = r_pixelOutValid;
  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = r_done;

endmodule
`default_nettype wire
